// File: rtl/cache_arbiter_control_pkg.sv
// Shared types for the L1-to-L2 arbiter control.
// Holds the arbiter state enum and the mux select encodings used by the
// interconnect datapath, plus a helper mapping a select to its access state.
package cache_arbiter_control_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_I_ACCESS = 2'd1,
    ARB_D_ACCESS = 2'd2
  } arb_state_t;

  localparam logic ARB_SEL_I = 1'b0;
  localparam logic ARB_SEL_D = 1'b1;

  function automatic arb_state_t accessStateFor(input logic sel);
    return (sel == ARB_SEL_D) ? ARB_D_ACCESS : ARB_I_ACCESS;
  endfunction

endpackage

// File: rtl/cache_arbiter_control_arb_watchdog.sv
// Response watchdog for the arbiter: counts access cycles spent waiting for
// the L2 completion and flags when the count reaches WDOG_CYCLES.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - restart the count (a new access is being entered)
//   count_i     - one more access cycle passed without a completion
//   expired_o   - count equals WDOG_CYCLES (never asserted when WDOG_CYCLES = 0)
module arb_watchdog #(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;

  // Clear wins over counting; the counter saturates instead of wrapping so a
  // very long stall can never alias back onto the compare value.
  always_comb begin
    wdog_d = wdog_q;
    if (clear_i) begin
      wdog_d = '0;
    end else if (count_i && (wdog_q != '1)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign expired_o = (WDOG_CYCLES != 0) && (wdog_q == WDOG_W'(WDOG_CYCLES));

endmodule

// File: rtl/cache_arbiter_control.sv
// Control half of the L1-to-L2 interconnect. Arbitrates the single L2 port
// between icache and dcache (round-robin on conflict, no bubble between
// back-to-back grants), drives the datapath mux selects, forwards strobes and
// completions, and keeps a sticky protocol error flag.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   icache_read/_write            - icache L2 request, level
//   dcache_read/_write            - dcache L2 request, level
//   icache_resp, dcache_resp      - one-cycle completion to the granted cache
//   l2_read, l2_write, l2_resp    - L2 strobes out, L2 completion in
//   l2wdatamux_sel, l2selmux_sel,
//   l2adrmux_sel                  - datapath selects, 0 = icache, 1 = dcache
//   protocol_err                  - sticky, cleared only by rst_n
module cache_arbiter_control
  import cache_arbiter_control_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 255,
  parameter int unsigned WDOG_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic icache_read,
  input  logic icache_write,
  input  logic dcache_read,
  input  logic dcache_write,
  output logic icache_resp,
  output logic dcache_resp,
  output logic l2_read,
  output logic l2_write,
  input  logic l2_resp,
  output logic l2wdatamux_sel,
  output logic l2selmux_sel,
  output logic l2adrmux_sel,
  output logic protocol_err
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       lastGrant_q, lastGrant_d;
  logic       protocolErr_q;

  logic ireq, dreq;
  logic inAccess;
  logic curRd, curWr;
  logic otherReq;
  logic wdogClear, wdogCount, wdogExpired;
  logic errSet;

  assign ireq     = icache_read | icache_write;
  assign dreq     = dcache_read | dcache_write;
  assign inAccess = (state_q != ARB_IDLE);
  assign curRd    = (grant_q == ARB_SEL_D) ? dcache_read  : icache_read;
  assign curWr    = (grant_q == ARB_SEL_D) ? dcache_write : icache_write;
  assign otherReq = (grant_q == ARB_SEL_D) ? ireq : dreq;

  // State and grant registers. grant drives the selects, so it resets to the
  // icache encoding and only moves when a new access is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= ARB_SEL_I;
      lastGrant_q <= ARB_SEL_I;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Next-state logic. On a completion the other requester is taken directly
  // if it is waiting, which is what makes the round-robin alternate and what
  // stops the finishing requester from being re-granted on the next cycle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      ARB_IDLE: begin
        if (ireq || dreq) begin
          if (ireq && dreq) begin
            grant_d = ~lastGrant_q;
          end else if (dreq) begin
            grant_d = ARB_SEL_D;
          end else begin
            grant_d = ARB_SEL_I;
          end
          lastGrant_d = grant_d;
          state_d     = accessStateFor(grant_d);
        end
      end
      ARB_I_ACCESS, ARB_D_ACCESS: begin
        if (l2_resp) begin
          if (otherReq) begin
            grant_d     = ~grant_q;
            lastGrant_d = ~grant_q;
            state_d     = accessStateFor(~grant_q);
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (!curRd && !curWr) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Outputs. Strobes and completions pass straight through from the granted
  // cache and L2 so there is no added latency inside an access.
  always_comb begin
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    icache_resp    = 1'b0;
    dcache_resp    = 1'b0;
    l2wdatamux_sel = grant_q;
    l2selmux_sel   = grant_q;
    l2adrmux_sel   = grant_q;
    case (state_q)
      ARB_I_ACCESS: begin
        l2_read     = icache_read;
        l2_write    = icache_write;
        icache_resp = l2_resp;
      end
      ARB_D_ACCESS: begin
        l2_read     = dcache_read;
        l2_write    = dcache_write;
        dcache_resp = l2_resp;
      end
      default: begin
      end
    endcase
  end

  // Any state change into an access state starts a fresh wait, including the
  // direct I-to-D / D-to-I handover.
  assign wdogClear = (state_d != ARB_IDLE) && (state_d != state_q);
  assign wdogCount = inAccess && !l2_resp;

  arb_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .WDOG_W      (WDOG_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wdogClear),
    .count_i   (wdogCount),
    .expired_o (wdogExpired)
  );

  // Protocol violations: stray completion in IDLE, read and write together,
  // request withdrawn before completion, or the watchdog running out.
  assign errSet = (!inAccess && l2_resp)
                | (inAccess && curRd && curWr)
                | (inAccess && !curRd && !curWr && !l2_resp)
                | (inAccess && wdogExpired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocolErr_q <= 1'b0;
    end else begin
      protocolErr_q <= protocolErr_q | errSet;
    end
  end

  assign protocol_err = protocolErr_q;

endmodule
